keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 167 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives rows one at a time, debounces presses and
// releases on a slow scan tick, and hands confirmed key codes over a valid/ready pair.
module keypad_scanner #(
  parameter int F_CLK          = 50000000,
  parameter int F_SCAN         = 1000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_col,
  input  logic       i_key_ready,
  output logic [3:0] o_row,
  output logic [3:0] o_key_code,
  output logic       o_key_valid,
  output logic       o_key_held,
  output logic       o_overrun
);

  localparam int TP = F_CLK / F_SCAN;
  localparam int TW = (TP > 1) ? $clog2(TP) : 1;
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [TW-1:0] TP_LAST  = TW'(TP - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_TICKS - 1);

  localparam logic [1:0] S_SCAN      = 2'd0;
  localparam logic [1:0] S_DEB_PRESS = 2'd1;
  localparam logic [1:0] S_HELD      = 2'd2;
  localparam logic [1:0] S_DEB_REL   = 2'd3;

  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [TW-1:0] r_tick_cnt;
  logic [1:0]    r_state;
  logic [DW-1:0] r_deb_cnt;
  logic [3:0]    r_row;
  logic [1:0]    r_row_idx;
  logic [1:0]    r_key_row;
  logic [1:0]    r_key_col;
  logic [3:0]    r_key_code;
  logic          r_key_valid;
  logic          r_key_held;
  logic          r_overrun;

  logic          w_tick;
  logic          w_any_low;
  logic [1:0]    w_low_col;
  logic          w_deb_done;
  logic          w_take;

  function automatic logic [1:0] lowest_low(input logic [3:0] cols);
    logic [1:0] idx;
    if (!cols[0]) begin
      idx = 2'd0;
    end else if (!cols[1]) begin
      idx = 2'd1;
    end else if (!cols[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  assign w_tick     = (r_tick_cnt == TP_LAST);
  assign w_any_low  = (r_sync2 != 4'hF);
  assign w_low_col  = lowest_low(r_sync2);
  assign w_deb_done = (r_deb_cnt == DEB_LAST);
  assign w_take     = r_key_valid && i_key_ready;

  // Column synchronizer and scan-tick divider.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1    <= 4'hF;
      r_sync2    <= 4'hF;
      r_tick_cnt <= '0;
    end else begin
      r_sync1    <= i_col;
      r_sync2    <= r_sync1;
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
    end
  end

  // Scan/debounce FSM together with the key handoff registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_SCAN;
      r_deb_cnt   <= '0;
      r_row       <= 4'b1110;
      r_row_idx   <= 2'd0;
      r_key_row   <= 2'd0;
      r_key_col   <= 2'd0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      // A confirm later in this block overrides the handshake clear.
      if (w_take) begin
        r_key_valid <= 1'b0;
      end
      if (w_tick) begin
        case (r_state)
          S_SCAN: begin
            if (!w_any_low) begin
              r_row     <= {r_row[2:0], r_row[3]};
              r_row_idx <= r_row_idx + 2'd1;
            end else begin
              r_key_row <= r_row_idx;
              r_key_col <= w_low_col;
              r_deb_cnt <= '0;
              r_state   <= S_DEB_PRESS;
            end
          end
          S_DEB_PRESS: begin
            if (w_any_low && (w_low_col == r_key_col)) begin
              if (w_deb_done) begin
                r_state    <= S_HELD;
                r_key_held <= 1'b1;
                if (!r_key_valid || i_key_ready) begin
                  r_key_code  <= {r_key_row, r_key_col};
                  r_key_valid <= 1'b1;
                end else begin
                  r_overrun <= 1'b1;
                end
              end else begin
                r_deb_cnt <= r_deb_cnt + DW'(1);
              end
            end else begin
              r_deb_cnt <= '0;
              r_state   <= S_SCAN;
            end
          end
          S_HELD: begin
            if (!w_any_low) begin
              r_deb_cnt <= '0;
              r_state   <= S_DEB_REL;
            end
          end
          S_DEB_REL: begin
            if (!w_any_low) begin
              if (w_deb_done) begin
                r_key_held <= 1'b0;
                r_row      <= {r_row[2:0], r_row[3]};
                r_row_idx  <= r_row_idx + 2'd1;
                r_state    <= S_SCAN;
              end else begin
                r_deb_cnt <= r_deb_cnt + DW'(1);
              end
            end else begin
              r_state <= S_HELD;
            end
          end
          default: begin
            r_state <= S_SCAN;
          end
        endcase
      end
    end
  end

  assign o_row       = r_row;
  assign o_key_code  = r_key_code;
  assign o_key_valid = r_key_valid;
  assign o_key_held  = r_key_held;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a simulated key matrix under random presses, bounce,
// ready and resets, checked every cycle against a tick-level behavioural model.
module tb_keypad_scanner;
  localparam int TP  = 4;
  localparam int DEB = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] col;
  logic       key_ready;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       overrun;

  always #5 clk = ~clk;

  keypad_scanner #(.F_CLK(4), .F_SCAN(1), .DEBOUNCE_TICKS(DEB)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_col(col), .i_key_ready(key_ready),
    .o_row(row), .o_key_code(key_code), .o_key_valid(key_valid),
    .o_key_held(key_held), .o_overrun(overrun)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase of the key handling, advanced once per scan tick.
  typedef enum int {M_SCAN, M_PRESS, M_HELD, M_REL} mphase_t;
  mphase_t    m_ph;
  int         m_row, m_krow, m_kcol, m_run, m_code, m_since;
  bit         m_valid, m_held, m_ovr;
  logic [3:0] m_sync[$];
  bit [15:0]  keys;

  function automatic int lowest(input logic [3:0] c);
    for (int i = 0; i < 4; i++) if (!c[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_ph = M_SCAN; m_row = 0; m_krow = 0; m_kcol = 0; m_run = 0; m_code = 0;
    m_since = 0; m_valid = 0; m_held = 0; m_ovr = 0;
    m_sync.delete(); m_sync.push_back(4'hF); m_sync.push_back(4'hF);
  endtask

  task automatic model_edge(input bit rst_v, input logic [3:0] col_v, input bit rdy_v);
    logic [3:0] cols;
    bit confirm;
    if (!rst_v) begin
      model_reset();
      return;
    end
    cols = m_sync.pop_front();
    m_sync.push_back(col_v);
    m_since++;
    confirm = 0;
    if (m_since % TP == 0) begin
      case (m_ph)
        M_SCAN:
          if (cols == 4'hF) m_row = (m_row + 1) % 4;
          else begin m_krow = m_row; m_kcol = lowest(cols); m_run = 0; m_ph = M_PRESS; end
        M_PRESS:
          if (lowest(cols) == m_kcol) begin
            m_run++;
            if (m_run == DEB) begin confirm = 1; m_ph = M_HELD; end
          end else begin m_run = 0; m_ph = M_SCAN; end
        M_HELD:
          if (cols == 4'hF) begin m_run = 0; m_ph = M_REL; end
        M_REL:
          if (cols == 4'hF) begin
            m_run++;
            if (m_run == DEB) begin m_held = 0; m_row = (m_row + 1) % 4; m_ph = M_SCAN; end
          end else m_ph = M_HELD;
        default: m_ph = M_SCAN;
      endcase
    end
    if (confirm) begin
      m_held = 1;
      if (!m_valid || rdy_v) begin m_code = m_krow * 4 + m_kcol; m_valid = 1; end
      else m_ovr = 1;
    end else if (m_valid && rdy_v) begin
      m_valid = 0;
    end
  endtask

  function automatic bit confirm_next();
    return (m_ph == M_PRESS) && (m_run == DEB - 1) && ((m_since + 1) % TP == 0)
           && (lowest(m_sync[0]) == m_kcol);
  endfunction

  // Electrical view of the matrix: a pressed key pulls its column low while its row is driven.
  function automatic logic [3:0] phys_col(input logic [3:0] drive, input bit [15:0] k);
    logic [3:0] c = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int cc = 0; cc < 4; cc++)
        if (!drive[r] && k[r*4+cc]) c[cc] = 1'b0;
    return c;
  endfunction

  task automatic step(input bit rst_v, input bit rdy_v, input bit bounce);
    logic [3:0] c;
    @(negedge clk);
    c = phys_col(row, keys);
    if (bounce && ($urandom_range(0, 3) == 0)) c = 4'hF;
    col = c; rst_n = rst_v; key_ready = rdy_v;
    @(posedge clk);
    model_edge(rst_v, c, rdy_v);
    #1;
    chk("row", row, 15 ^ (1 << m_row));
    chk("code", key_code, m_code);
    chk("valid", key_valid, m_valid);
    chk("held", key_held, m_held);
    chk("overrun", overrun, m_ovr);
  endtask

  task automatic wait_held(input bit want, input int max_cyc);
    for (int i = 0; i < max_cyc && m_held != want; i++) step(1'b1, 1'b0, 1'b0);
    chk("wait_held", key_held, want);
  endtask

  task automatic wait_phase(input mphase_t ph, input int max_cyc);
    for (int i = 0; i < max_cyc && m_ph != ph; i++) step(1'b1, 1'b0, 1'b0);
    chk("wait_phase", int'(m_ph), int'(ph));
  endtask

  initial begin
    keys = '0; col = 4'hF; key_ready = 1'b0; rst_n = 1'b0;
    model_reset();
    repeat (3) step(1'b0, 1'b0, 1'b0);

    repeat (40) step(1'b1, 1'b0, 1'b0);
    chk("idle_valid", key_valid, 0);

    keys = 16'h1 << 6;
    wait_phase(M_PRESS, 100);
    keys = '0;
    repeat (TP) step(1'b1, 1'b0, 1'b0);
    keys = 16'h1 << 6;
    wait_held(1'b1, 200);
    chk("press_code", key_code, 6);
    chk("press_row", row, 4'b1101);
    repeat (5) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("handshake_valid", key_valid, 0);
    keys = '0;
    wait_held(1'b0, 200);
    chk("release_row", row, 4'b1011);

    keys = 16'h1 << 6;
    wait_held(1'b1, 200);
    keys = '0;
    wait_held(1'b0, 200);
    keys = 16'h1 << 9;
    wait_held(1'b1, 200);
    chk("overrun_code", key_code, 6);
    chk("overrun_flag", overrun, 1);

    step(1'b0, 1'b0, 1'b0);
    keys = 16'h1 << 6;
    wait_held(1'b1, 200);
    keys = '0;
    wait_held(1'b0, 200);
    keys = 16'h1 << 9;
    for (int i = 0; i < 200 && !m_held; i++) step(1'b1, confirm_next(), 1'b0);
    chk("ready_confirm_code", key_code, 9);
    chk("ready_confirm_ovr", overrun, 0);
    chk("ready_confirm_valid", key_valid, 1);

    keys = '0;
    wait_held(1'b0, 200);
    keys = 16'h1 << 13;
    wait_phase(M_PRESS, 100);
    step(1'b0, 1'b0, 1'b0);
    chk("rst_row", row, 4'b1110);
    chk("rst_valid", key_valid, 0);
    chk("rst_held", key_held, 0);

    for (int ep = 0; ep < 60; ep++) begin
      bit bounce = ($urandom_range(0, 2) == 0);
      int hold = $urandom_range(10, 150);
      keys = '0;
      if ($urandom_range(0, 4) != 0) keys[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 2) == 0) keys[$urandom_range(0, 15)] = 1'b1;
      for (int i = 0; i < hold; i++)
        step(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) == 0), bounce);
      keys = '0;
      for (int i = 0; i < $urandom_range(20, 80); i++)
        step(1'b1, ($urandom_range(0, 7) == 0), bounce);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
